exec_decode_unit: RTL and testbench
===================================

# exec_decode_unit

Decode/execute slice of the multi-cycle RV32E core. It registers one 32-bit instruction and produces the immediate, datapath mux selects and per-stage microcode. A registered ALU computes arithmetic, logic, shift, set-less-than and branch-compare results. Two registered adders produce PC+4 and PC+imm. The core sequencer drives `decode_en`/`execute_en` one-hot per stage.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset)
- decode_en  in  1  latch and decode `instr` on this edge
- execute_en  in  1  capture ALU and PC-adder results on this edge
- instr  in  32  instruction word
- pc  in  32  current PC
- rs1_data, rs2_data  in  32 each  register-file read data
- imm  out  32  sign/shift-extended immediate
- alu_a_sel  out  1  1 = ALU A takes `pc`, else `rs1_data`
- alu_b_sel  out  1  1 = ALU B takes `imm`, else `rs2_data`
- wb_sel  out  2  write-back source: 00 ALU, 01 imm, 10 memory, 11 next_pc
- rd_rf_uc  out  10  [9] read enable, [8] 0, [7:4] rs1, [3:0] rs2
- ex_alu_uc  out  6  [5] ALU enable, [4] 0, [3:0] ALU op
- ma_mem_uc  out  5  [4] access, [3] unsigned, [2] write, [1:0] size (0 B, 1 H, 2 W)
- wb_rf_uc  out  10  [9] enable, [8] write, [7:4] rd, [3:0] 0
- wb_pc_uc  out  2  PC source: 00 next_pc, 01 alu_out, 10 offset_pc, 11 offset_pc if alu_out[0] else next_pc
- alu_out, next_pc, offset_pc  out  32 each  registered results
- fault  out  1  decode fault

## Operation
- ALU op encoding: {funct7[5], funct3} for ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Compare ops produce 1 or 0 in bit 0: EQ 1001, NE 1010, LT 1011, GE 1100, LTU 1110, GEU 1111.
- ALU arithmetic wraps mod 2^32. Shift amount is b[4:0].
- `alu_a_sel`/`alu_b_sel` are consumed inside the block to select the ALU operands.
- Decode per class:
  - OP-IMM: B=imm, for SRAI/SRLI, op[3] = instr[30].
  - OP: register-register.
  - LUI: wb_sel 01.
  - AUIPC: A=pc, B=imm, ADD.
  - JAL: wb_sel 11, pc_uc 10, ALU disabled.
  - JALR: ADD rs1+imm, wb_sel 11, pc_uc 01.
  - BRANCH: compare op, pc_uc 11, no RF write.
  - LOAD: ADD rs1+imm, mem access, unsigned = funct3[2], wb_sel 10.
  - STORE: ADD rs1+imm, mem write, no RF write.
  - FENCE: all enables 0, no fault.
- Immediates: I, S, B, U, J formats per RV32I, sign-extended. B and J immediates have bit 0 = 0.
- Fault (all microcode enables cleared, imm = 0):
  - unknown opcode, funct3 or funct7;
  - any used rs1/rs2/rd field with bit 4 set (RV32E);
  - ECALL/EBREAK;
  - LOAD funct3 011/11x, STORE funct3 ≥ 011.
- Unused register fields read as 0 in microcode. rd = x0 still sets wb enable; the register file ignores x0 writes.

## Timing
- All outputs are registered. Reset (reset=0) drives every output to 0, fault 0.
- decode_en=1: decode outputs and `fault` valid the cycle after the edge. They are held until the next decode_en. A fault clears on the next legal decode.
- execute_en=1: next_pc = pc+4, offset_pc = pc+imm. alu_out updates only if ex_alu_uc[5]=1, else it holds.
- Both results are valid the cycle after the edge.
- decode_en and execute_en both 1: execute uses the previously registered decode outputs, and decode updates.
- Reset has priority over both enables mid-operation.

## Configuration
- `EXU_BRANCH_EN` defined: BRANCH opcodes decode and compare ops execute as specified.
- `EXU_BRANCH_EN` undefined:
  - BRANCH opcodes raise fault.
  - ALU compare ops 1001–1100, 1110, 1111 return 0.

## Test plan
- Reset: hold reset=0 for 2 cycles -> all outputs 0, fault 0.
- ADDI x1,x2,-5 (0xFFB10093): decode, then execute with rs1=10, pc=0x100.
  - Decode -> imm=0xFFFFFFFB, rd_rf_uc=0x220, ex_alu_uc=0x20, wb_rf_uc=0x310, alu_b_sel=1, wb_sel=00.
  - Execute -> alu_out=5, next_pc=0x104, offset_pc=0xFB.
- SUB x3,x1,x2 with rs1=3, rs2=7 -> alu_out=0xFFFFFFFC.
- SRA with rs1=0x80000000, rs2=4 -> alu_out=0xF8000000.
- BEQ x1,x2,+8 (0x00208463) with equal operands -> alu_out=1, wb_pc_uc=11, offset_pc=pc+8, wb_rf_uc[9]=0.
- Fault cases: instr=0xFFFFFFFF -> fault=1 and all enables 0. ADDI with rd=x16 -> fault=1. A following legal decode clears fault.

Source files
------------

// File: rtl/exec_decode_unit_if.sv
// rtl/exec_decode_unit_if.sv - sequencer/datapath bundle of the RV32E decode/execute slice
// master drives instruction, operands and stage enables; slave returns decode and execute results
interface exec_decode_unit_if;
  logic        decode_en;
  logic        execute_en;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  wb_sel;
  logic [9:0]  rd_rf_uc;
  logic [5:0]  ex_alu_uc;
  logic [4:0]  ma_mem_uc;
  logic [9:0]  wb_rf_uc;
  logic [1:0]  wb_pc_uc;
  logic [31:0] alu_out;
  logic [31:0] next_pc;
  logic [31:0] offset_pc;
  logic        fault;

  modport master (
    output decode_en, execute_en, instr, pc, rs1_data, rs2_data,
    input  imm, alu_a_sel, alu_b_sel, wb_sel, rd_rf_uc, ex_alu_uc, ma_mem_uc,
    input  wb_rf_uc, wb_pc_uc, alu_out, next_pc, offset_pc, fault
  );

  modport slave (
    input  decode_en, execute_en, instr, pc, rs1_data, rs2_data,
    output imm, alu_a_sel, alu_b_sel, wb_sel, rd_rf_uc, ex_alu_uc, ma_mem_uc,
    output wb_rf_uc, wb_pc_uc, alu_out, next_pc, offset_pc, fault
  );
endinterface

// File: rtl/exec_decode_unit.sv
// rtl/exec_decode_unit.sv - RV32E decode/execute slice: registered decode, ALU and PC adders
// BRANCH decode and ALU compare ops are present only when EXU_BRANCH_EN is defined
module exec_decode_unit (
  input  logic              clk,
  input  logic              reset,
  exec_decode_unit_if.slave bus
);
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_EQ   = 4'b1001;
  localparam logic [3:0] ALU_NE   = 4'b1010;
  localparam logic [3:0] ALU_LT   = 4'b1011;
  localparam logic [3:0] ALU_GE   = 4'b1100;
  localparam logic [3:0] ALU_LTU  = 4'b1110;
  localparam logic [3:0] ALU_GEU  = 4'b1111;

  logic [31:0] imm_q, imm_d;
  logic        alu_a_sel_q, alu_a_sel_d;
  logic        alu_b_sel_q, alu_b_sel_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [9:0]  rd_rf_uc_q, rd_rf_uc_d;
  logic [5:0]  ex_alu_uc_q, ex_alu_uc_d;
  logic [4:0]  ma_mem_uc_q, ma_mem_uc_d;
  logic [9:0]  wb_rf_uc_q, wb_rf_uc_d;
  logic [1:0]  wb_pc_uc_q, wb_pc_uc_d;
  logic        fault_q, fault_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [31:0] offset_pc_q, offset_pc_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_f;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;

  assign opcode = bus.instr[6:0];
  assign rd_f   = bus.instr[11:7];
  assign funct3 = bus.instr[14:12];
  assign rs1_f  = bus.instr[19:15];
  assign rs2_f  = bus.instr[24:20];
  assign funct7 = bus.instr[31:25];

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_u = {bus.instr[31:12], 12'h000};
  assign imm_j = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                  bus.instr[20], bus.instr[30:21], 1'b0};
`ifdef EXU_BRANCH_EN
  logic [31:0] imm_b;
  assign imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                  bus.instr[30:25], bus.instr[11:8], 1'b0};
`endif

  logic        illegal;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        dec_fault;
  logic [31:0] dec_imm;
  logic        dec_a_sel;
  logic        dec_b_sel;
  logic        dec_alu_en;
  logic [3:0]  dec_op;
  logic [1:0]  dec_wb_sel;
  logic [1:0]  dec_pc_uc;
  logic [4:0]  dec_mem;

  always_comb begin
    illegal    = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    dec_imm    = 32'h0;
    dec_a_sel  = 1'b0;
    dec_b_sel  = 1'b0;
    dec_alu_en = 1'b0;
    dec_op     = ALU_ADD;
    dec_wb_sel = 2'b00;
    dec_pc_uc  = 2'b00;
    dec_mem    = 5'h00;
    case (opcode)
      OPC_OP_IMM: begin
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        dec_b_sel  = 1'b1;
        dec_alu_en = 1'b1;
        dec_imm    = imm_i;
        dec_op     = {1'b0, funct3};
        // Shift-immediates keep the shamt in the low imm bits; funct7 qualifies the op
        if (funct3 == 3'b001) begin
          illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          dec_op  = {funct7[5], funct3};
        end
      end
      OPC_OP: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        use_rd     = 1'b1;
        dec_alu_en = 1'b1;
        dec_op     = {funct7[5], funct3};
        if (funct7 == 7'b0000000) begin
          illegal = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        use_rd     = 1'b1;
        dec_imm    = imm_u;
        dec_wb_sel = 2'b01;
      end
      OPC_AUIPC: begin
        use_rd     = 1'b1;
        dec_imm    = imm_u;
        dec_a_sel  = 1'b1;
        dec_b_sel  = 1'b1;
        dec_alu_en = 1'b1;
      end
      OPC_JAL: begin
        use_rd     = 1'b1;
        dec_imm    = imm_j;
        dec_wb_sel = 2'b11;
        dec_pc_uc  = 2'b10;
      end
      OPC_JALR: begin
        illegal    = (funct3 != 3'b000);
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        dec_imm    = imm_i;
        dec_b_sel  = 1'b1;
        dec_alu_en = 1'b1;
        dec_wb_sel = 2'b11;
        dec_pc_uc  = 2'b01;
      end
`ifdef EXU_BRANCH_EN
      OPC_BRANCH: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec_imm    = imm_b;
        dec_alu_en = 1'b1;
        dec_pc_uc  = 2'b11;
        case (funct3)
          3'b000:  dec_op = ALU_EQ;
          3'b001:  dec_op = ALU_NE;
          3'b100:  dec_op = ALU_LT;
          3'b101:  dec_op = ALU_GE;
          3'b110:  dec_op = ALU_LTU;
          3'b111:  dec_op = ALU_GEU;
          default: illegal = 1'b1;
        endcase
      end
`else
      OPC_BRANCH: begin
        illegal = 1'b1;
      end
`endif
      OPC_LOAD: begin
        illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        use_rs1    = 1'b1;
        use_rd     = 1'b1;
        dec_imm    = imm_i;
        dec_b_sel  = 1'b1;
        dec_alu_en = 1'b1;
        dec_wb_sel = 2'b10;
        dec_mem    = {1'b1, funct3[2], 1'b0, funct3[1:0]};
      end
      OPC_STORE: begin
        illegal    = (funct3 >= 3'b011);
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec_imm    = imm_s;
        dec_b_sel  = 1'b1;
        dec_alu_en = 1'b1;
        dec_mem    = {1'b1, 1'b0, 1'b1, funct3[1:0]};
      end
      OPC_FENCE: begin
        illegal = (funct3[2:1] != 2'b00);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // RV32E has only x0..x15; a referenced register with bit 4 set is a decode fault
  assign dec_fault = illegal
                   | (use_rs1 & rs1_f[4])
                   | (use_rs2 & rs2_f[4])
                   | (use_rd  & rd_f[4]);

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;

  assign alu_a = alu_a_sel_q ? bus.pc : bus.rs1_data;
  assign alu_b = alu_b_sel_q ? imm_q  : bus.rs2_data;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = 32'h0;
    case (ex_alu_uc_q[3:0])
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << shamt;
      ALU_SLT:  alu_res = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'h0, alu_a < alu_b};
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SRL:  alu_res = alu_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
`ifdef EXU_BRANCH_EN
      ALU_EQ:   alu_res = {31'h0, alu_a == alu_b};
      ALU_NE:   alu_res = {31'h0, alu_a != alu_b};
      ALU_LT:   alu_res = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_GE:   alu_res = {31'h0, $signed(alu_a) >= $signed(alu_b)};
      ALU_LTU:  alu_res = {31'h0, alu_a < alu_b};
      ALU_GEU:  alu_res = {31'h0, alu_a >= alu_b};
`endif
      default:  alu_res = 32'h0;
    endcase
  end

  always_comb begin
    imm_d       = imm_q;
    alu_a_sel_d = alu_a_sel_q;
    alu_b_sel_d = alu_b_sel_q;
    wb_sel_d    = wb_sel_q;
    rd_rf_uc_d  = rd_rf_uc_q;
    ex_alu_uc_d = ex_alu_uc_q;
    ma_mem_uc_d = ma_mem_uc_q;
    wb_rf_uc_d  = wb_rf_uc_q;
    wb_pc_uc_d  = wb_pc_uc_q;
    fault_d     = fault_q;
    alu_out_d   = alu_out_q;
    next_pc_d   = next_pc_q;
    offset_pc_d = offset_pc_q;

    if (bus.decode_en) begin
      if (dec_fault) begin
        imm_d       = 32'h0;
        alu_a_sel_d = 1'b0;
        alu_b_sel_d = 1'b0;
        wb_sel_d    = 2'b00;
        rd_rf_uc_d  = 10'h000;
        ex_alu_uc_d = 6'h00;
        ma_mem_uc_d = 5'h00;
        wb_rf_uc_d  = 10'h000;
        wb_pc_uc_d  = 2'b00;
        fault_d     = 1'b1;
      end else begin
        imm_d       = dec_imm;
        alu_a_sel_d = dec_a_sel;
        alu_b_sel_d = dec_b_sel;
        wb_sel_d    = dec_wb_sel;
        rd_rf_uc_d  = {use_rs1 | use_rs2, 1'b0,
                       use_rs1 ? rs1_f[3:0] : 4'h0,
                       use_rs2 ? rs2_f[3:0] : 4'h0};
        ex_alu_uc_d = {dec_alu_en, 1'b0, dec_alu_en ? dec_op : 4'h0};
        ma_mem_uc_d = dec_mem;
        wb_rf_uc_d  = {use_rd, use_rd, use_rd ? rd_f[3:0] : 4'h0, 4'h0};
        wb_pc_uc_d  = dec_pc_uc;
        fault_d     = 1'b0;
      end
    end

    // Execute reads the decode registers, so a same-edge decode only affects the next execute
    if (bus.execute_en) begin
      next_pc_d   = bus.pc + 32'd4;
      offset_pc_d = bus.pc + imm_q;
      if (ex_alu_uc_q[5]) begin
        alu_out_d = alu_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      imm_q       <= 32'h0;
      alu_a_sel_q <= 1'b0;
      alu_b_sel_q <= 1'b0;
      wb_sel_q    <= 2'b00;
      rd_rf_uc_q  <= 10'h000;
      ex_alu_uc_q <= 6'h00;
      ma_mem_uc_q <= 5'h00;
      wb_rf_uc_q  <= 10'h000;
      wb_pc_uc_q  <= 2'b00;
      fault_q     <= 1'b0;
      alu_out_q   <= 32'h0;
      next_pc_q   <= 32'h0;
      offset_pc_q <= 32'h0;
    end else begin
      imm_q       <= imm_d;
      alu_a_sel_q <= alu_a_sel_d;
      alu_b_sel_q <= alu_b_sel_d;
      wb_sel_q    <= wb_sel_d;
      rd_rf_uc_q  <= rd_rf_uc_d;
      ex_alu_uc_q <= ex_alu_uc_d;
      ma_mem_uc_q <= ma_mem_uc_d;
      wb_rf_uc_q  <= wb_rf_uc_d;
      wb_pc_uc_q  <= wb_pc_uc_d;
      fault_q     <= fault_d;
      alu_out_q   <= alu_out_d;
      next_pc_q   <= next_pc_d;
      offset_pc_q <= offset_pc_d;
    end
  end

  assign bus.imm       = imm_q;
  assign bus.alu_a_sel = alu_a_sel_q;
  assign bus.alu_b_sel = alu_b_sel_q;
  assign bus.wb_sel    = wb_sel_q;
  assign bus.rd_rf_uc  = rd_rf_uc_q;
  assign bus.ex_alu_uc = ex_alu_uc_q;
  assign bus.ma_mem_uc = ma_mem_uc_q;
  assign bus.wb_rf_uc  = wb_rf_uc_q;
  assign bus.wb_pc_uc  = wb_pc_uc_q;
  assign bus.fault     = fault_q;
  assign bus.alu_out   = alu_out_q;
  assign bus.next_pc   = next_pc_q;
  assign bus.offset_pc = offset_pc_q;
endmodule

// File: tb/tb_exec_decode_unit.sv
// tb/tb_exec_decode_unit.sv - vector table, corner sequences and random checks of exec_decode_unit
module tb_exec_decode_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_decode_unit_if bus();
  exec_decode_unit dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] imm;
    logic        a_sel;
    logic        b_sel;
    logic [1:0]  wb_sel;
    logic [9:0]  rd_uc;
    logic [5:0]  ex_uc;
    logic [4:0]  mem_uc;
    logic [9:0]  wb_rf;
    logic [1:0]  wb_pc;
    logic        fault;
  } dec_t;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2, imm;
    logic [9:0]  rd_uc;
    logic [5:0]  ex_uc;
    logic [4:0]  mem_uc;
    logic [9:0]  wb_rf;
    logic [1:0]  wb_pc, wb_sel;
    logic        fault, chk_alu;
    logic [31:0] alu, nxt, off;
  } vec_t;

  dec_t        cur;
  logic [31:0] m_alu, m_next, m_off;
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] half;
    half = 32'h1 << (bits - 1);
    return (v ^ half) - half;
  endfunction

  function automatic dec_t decode_ref(input logic [31:0] w);
    dec_t d;
    int opc, f3, f7, rd, rs1, rs2, op, mem;
    bit ok, u1, u2, ud, alu;
    int cmp_op [8];
    cmp_op = '{9, 10, -1, -1, 11, 12, 14, 15};
    opc = int'(w[6:0]);   f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    rd  = int'(w[11:7]);  rs1 = int'(w[19:15]); rs2 = int'(w[24:20]);
    d = '0; ok = 1; u1 = 0; u2 = 0; ud = 0; alu = 0; op = 0; mem = 0;
    case (opc)
      'h13: begin
        u1 = 1; ud = 1; alu = 1; d.b_sel = 1; op = f3;
        d.imm = sext(32'(w[31:20]), 12);
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin
          ok = (f7 == 0) || (f7 == 'h20);
          if (f7 == 'h20) op = 13;
        end
      end
      'h33: begin
        u1 = 1; u2 = 1; ud = 1; alu = 1;
        op = f3 + ((f7 == 'h20) ? 8 : 0);
        ok = (f7 == 0) || ((f7 == 'h20) && (f3 == 0 || f3 == 5));
      end
      'h37: begin ud = 1; d.wb_sel = 1; d.imm = w & 32'hFFFFF000; end
      'h17: begin ud = 1; alu = 1; d.a_sel = 1; d.b_sel = 1; d.imm = w & 32'hFFFFF000; end
      'h6F: begin
        ud = 1; d.wb_sel = 3; d.wb_pc = 2;
        d.imm = sext(32'(w[31]) * 32'h100000 + 32'(w[19:12]) * 32'h1000 +
                     32'(w[20]) * 32'h800 + 32'(w[30:21]) * 2, 21);
      end
      'h67: begin
        ok = (f3 == 0); u1 = 1; ud = 1; alu = 1; d.b_sel = 1;
        d.wb_sel = 3; d.wb_pc = 1; d.imm = sext(32'(w[31:20]), 12);
      end
      'h63: begin
`ifdef EXU_BRANCH_EN
        u1 = 1; u2 = 1; alu = 1; d.wb_pc = 3;
        op = cmp_op[f3]; ok = (op >= 0);
        d.imm = sext(32'(w[31]) * 32'h1000 + 32'(w[7]) * 32'h800 +
                     32'(w[30:25]) * 32 + 32'(w[11:8]) * 2, 13);
`else
        ok = 0;
`endif
      end
      'h03: begin
        ok = (f3 != 3) && (f3 < 6); u1 = 1; ud = 1; alu = 1; d.b_sel = 1;
        d.wb_sel = 2; mem = 16 + ((f3 >= 4) ? 8 : 0) + f3 % 4;
        d.imm = sext(32'(w[31:20]), 12);
      end
      'h23: begin
        ok = (f3 < 3); u1 = 1; u2 = 1; alu = 1; d.b_sel = 1; mem = 20 + f3;
        d.imm = sext(32'(w[31:25]) * 32 + 32'(w[11:7]), 12);
      end
      'h0F: ok = (f3 < 2);
      default: ok = 0;
    endcase
    if ((u1 && rs1 > 15) || (u2 && rs2 > 15) || (ud && rd > 15)) ok = 0;
    if (!ok) begin
      d = '0;
      d.fault = 1;
      return d;
    end
    d.rd_uc  = 10'(((u1 || u2) ? 512 : 0) + (u1 ? (rs1 % 16) * 16 : 0) + (u2 ? rs2 % 16 : 0));
    d.ex_uc  = alu ? 6'(32 + op) : 6'd0;
    d.wb_rf  = ud ? 10'(768 + (rd % 16) * 16) : 10'd0;
    d.mem_uc = 5'(mem);
    return d;
  endfunction

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b % 32);
    sa = a;
    case (op)
      0:  return a + b;
      8:  return a - b;
      1:  return a << sh;
      2:  return ($signed(a) < $signed(b)) ? 1 : 0;
      3:  return (a < b) ? 1 : 0;
      4:  return a ^ b;
      5:  return a >> sh;
      13: return sa >>> sh;
      6:  return a | b;
      7:  return a & b;
`ifdef EXU_BRANCH_EN
      9:  return (a == b) ? 1 : 0;
      10: return (a != b) ? 1 : 0;
      11: return ($signed(a) < $signed(b)) ? 1 : 0;
      12: return ($signed(a) >= $signed(b)) ? 1 : 0;
      14: return (a < b) ? 1 : 0;
      15: return (a >= b) ? 1 : 0;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_exec(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2);
    logic [31:0] a, b;
    a = cur.a_sel ? pc : rs1;
    b = cur.b_sel ? cur.imm : rs2;
    if (cur.ex_uc[5]) m_alu = alu_ref(int'(cur.ex_uc[3:0]), a, b);
    m_next = pc + 4;
    m_off  = pc + cur.imm;
  endtask

  task automatic apply_decode(input logic [31:0] w);
    bus.instr = w;
    bus.decode_en = 1'b1;
    tick();
    bus.decode_en = 1'b0;
    cur = decode_ref(w);
  endtask

  task automatic apply_exec(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.pc = pc; bus.rs1_data = rs1; bus.rs2_data = rs2;
    bus.execute_en = 1'b1;
    tick();
    bus.execute_en = 1'b0;
    model_exec(pc, rs1, rs2);
  endtask

  task automatic apply_both(input logic [31:0] w, input logic [31:0] pc,
                            input logic [31:0] rs1, input logic [31:0] rs2);
    bus.instr = w; bus.pc = pc; bus.rs1_data = rs1; bus.rs2_data = rs2;
    bus.decode_en = 1'b1;
    bus.execute_en = 1'b1;
    tick();
    bus.decode_en = 1'b0;
    bus.execute_en = 1'b0;
    model_exec(pc, rs1, rs2);
    cur = decode_ref(w);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_imm"},       bus.imm,                cur.imm);
    chk({tag, "_alu_a_sel"}, 32'(bus.alu_a_sel),     32'(cur.a_sel));
    chk({tag, "_alu_b_sel"}, 32'(bus.alu_b_sel),     32'(cur.b_sel));
    chk({tag, "_wb_sel"},    32'(bus.wb_sel),        32'(cur.wb_sel));
    chk({tag, "_rd_rf_uc"},  32'(bus.rd_rf_uc),      32'(cur.rd_uc));
    chk({tag, "_ex_alu_uc"}, 32'(bus.ex_alu_uc),     32'(cur.ex_uc));
    chk({tag, "_ma_mem_uc"}, 32'(bus.ma_mem_uc),     32'(cur.mem_uc));
    chk({tag, "_wb_rf_uc"},  32'(bus.wb_rf_uc),      32'(cur.wb_rf));
    chk({tag, "_wb_pc_uc"},  32'(bus.wb_pc_uc),      32'(cur.wb_pc));
    chk({tag, "_fault"},     32'(bus.fault),         32'(cur.fault));
    chk({tag, "_alu_out"},   bus.alu_out,            m_alu);
    chk({tag, "_next_pc"},   bus.next_pc,            m_next);
    chk({tag, "_offset_pc"}, bus.offset_pc,          m_off);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [11];
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    int k;
    opcs = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0F, 7'h73};
    k = $urandom_range(0, 11);
    if (k == 11) return $urandom;
    rd  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : {1'b0, 4'($urandom)};
    rs1 = ($urandom_range(0, 5) == 0) ? 5'($urandom) : {1'b0, 4'($urandom)};
    rs2 = ($urandom_range(0, 5) == 0) ? 5'($urandom) : {1'b0, 4'($urandom)};
    f3  = 3'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h00;
      default: f7 = 7'($urandom);
    endcase
    return {f7, rs2, rs1, f3, rd, opcs[k]};
  endfunction

  initial begin
    vec_t v;
    reset = 1'b0;
    bus.decode_en = 1'b0; bus.execute_en = 1'b0;
    bus.instr = 32'h0; bus.pc = 32'h0; bus.rs1_data = 32'h0; bus.rs2_data = 32'h0;
    cur = '0; m_alu = 0; m_next = 0; m_off = 0;

    tick();
    tick();
    check_all("reset");
    reset = 1'b1;

    //               instr         pc      rs1           rs2     imm           rd     ex     mem    wb_rf   pc    wbs   flt   chk   alu           next    off
    vecs.push_back('{32'hFFB10093, 32'h100, 32'd10,      32'd0,  32'hFFFFFFFB, 10'h220, 6'h20, 5'h00, 10'h310, 2'd0, 2'd0, 1'b0, 1'b1, 32'd5,        32'h104, 32'hFB});
    vecs.push_back('{32'h010000EF, 32'h100, 32'd0,       32'd0,  32'h10,       10'h000, 6'h00, 5'h00, 10'h310, 2'd2, 2'd3, 1'b0, 1'b1, 32'd5,        32'h104, 32'h110});
    vecs.push_back('{32'h402081B3, 32'h200, 32'd3,       32'd7,  32'h0,        10'h212, 6'h28, 5'h00, 10'h330, 2'd0, 2'd0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h204, 32'h200});
    vecs.push_back('{32'h4020D1B3, 32'h200, 32'h80000000, 32'd4, 32'h0,        10'h212, 6'h2D, 5'h00, 10'h330, 2'd0, 2'd0, 1'b0, 1'b1, 32'hF8000000, 32'h204, 32'h200});
`ifdef EXU_BRANCH_EN
    vecs.push_back('{32'h00208463, 32'h300, 32'h55,      32'h55, 32'h8,        10'h212, 6'h29, 5'h00, 10'h000, 2'd3, 2'd0, 1'b0, 1'b1, 32'd1,        32'h304, 32'h308});
`else
    vecs.push_back('{32'h00208463, 32'h300, 32'h55,      32'h55, 32'h0,        10'h000, 6'h00, 5'h00, 10'h000, 2'd0, 2'd0, 1'b1, 1'b1, 32'hF8000000, 32'h304, 32'h300});
`endif
    vecs.push_back('{32'h00412083, 32'h400, 32'd100,     32'd0,  32'h4,        10'h220, 6'h20, 5'h12, 10'h310, 2'd0, 2'd2, 1'b0, 1'b1, 32'h68,       32'h404, 32'h404});
    vecs.push_back('{32'h123452B7, 32'h500, 32'd0,       32'd0,  32'h12345000, 10'h000, 6'h00, 5'h00, 10'h350, 2'd0, 2'd1, 1'b0, 1'b1, 32'h68,       32'h504, 32'h12345500});
    vecs.push_back('{32'hFFFFFFFF, 32'h600, 32'd0,       32'd0,  32'h0,        10'h000, 6'h00, 5'h00, 10'h000, 2'd0, 2'd0, 1'b1, 1'b1, 32'h68,       32'h604, 32'h600});
    vecs.push_back('{32'hFFB10813, 32'h700, 32'd10,      32'd0,  32'h0,        10'h000, 6'h00, 5'h00, 10'h000, 2'd0, 2'd0, 1'b1, 1'b1, 32'h68,       32'h704, 32'h700});
    vecs.push_back('{32'hFFB10093, 32'h800, 32'd10,      32'd0,  32'hFFFFFFFB, 10'h220, 6'h20, 5'h00, 10'h310, 2'd0, 2'd0, 1'b0, 1'b1, 32'd5,        32'h804, 32'h7FB});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      apply_decode(v.instr);
      chk($sformatf("v%0d_imm", i),       bus.imm,              v.imm);
      chk($sformatf("v%0d_rd_rf_uc", i),  32'(bus.rd_rf_uc),    32'(v.rd_uc));
      chk($sformatf("v%0d_ex_alu_uc", i), 32'(bus.ex_alu_uc),   32'(v.ex_uc));
      chk($sformatf("v%0d_ma_mem_uc", i), 32'(bus.ma_mem_uc),   32'(v.mem_uc));
      chk($sformatf("v%0d_wb_rf_uc", i),  32'(bus.wb_rf_uc),    32'(v.wb_rf));
      chk($sformatf("v%0d_wb_pc_uc", i),  32'(bus.wb_pc_uc),    32'(v.wb_pc));
      chk($sformatf("v%0d_wb_sel", i),    32'(bus.wb_sel),      32'(v.wb_sel));
      chk($sformatf("v%0d_fault", i),     32'(bus.fault),       32'(v.fault));
      apply_exec(v.pc, v.rs1, v.rs2);
      chk($sformatf("v%0d_next_pc", i),   bus.next_pc,          v.nxt);
      chk($sformatf("v%0d_offset_pc", i), bus.offset_pc,        v.off);
      if (v.chk_alu) chk($sformatf("v%0d_alu_out", i), bus.alu_out, v.alu);
    end

    // Same-edge decode and execute: execute consumes the ADDI, decode latches the SUB
    apply_decode(32'hFFB10093);
    apply_both(32'h402081B3, 32'h900, 32'd20, 32'd1);
    chk("both_alu_out",   bus.alu_out,            32'd15);
    chk("both_offset_pc", bus.offset_pc,          32'h8FB);
    chk("both_ex_alu_uc", 32'(bus.ex_alu_uc),     32'h28);
    apply_exec(32'h900, 32'd20, 32'd1);
    chk("both_sub_alu",   bus.alu_out,            32'd19);

    // Decode outputs hold across an idle cycle
    tick();
    check_all("hold");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] w, p, r1, r2;
      w  = rand_instr();
      p  = $urandom & 32'hFFFFFFFC;
      r1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      if ($urandom_range(0, 3) == 0) begin
        apply_both(w, p, r1, r2);
      end else begin
        apply_decode(w);
        check_all($sformatf("rnd%0d_dec", n));
        apply_exec(p, r1, r2);
      end
      check_all($sformatf("rnd%0d_ex", n));
    end

    // Reset wins over both enables
    bus.instr = 32'hFFB10093; bus.pc = 32'h1000; bus.rs1_data = 32'd7;
    bus.decode_en = 1'b1; bus.execute_en = 1'b1; reset = 1'b0;
    tick();
    bus.decode_en = 1'b0; bus.execute_en = 1'b0; reset = 1'b1;
    cur = '0; m_alu = 0; m_next = 0; m_off = 0;
    check_all("midreset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
